llc_pending_tracker: RTL and testbench

Parametrised tracker for outstanding LLC transactions: recalls, DMA reads and DMA writes. It replaces the single-entry `*_pending`, `req_in_stalled_set/tag` and `recall_evict_addr` flops with an N-entry table. It sits beside the LLC pipeline between decode and process. Decode allocates an entry when it issues a long-latency operation, process clears the entry on completion, and every incoming request's set/tag is matched against the table to produce the stall condition.

---
 rtl/llc_pending_tracker.sv | 147 ++++++++++++++
 tb/tb_llc_pending_tracker.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/llc_pending_tracker.sv
// N-entry table of outstanding LLC recalls / DMA reads / DMA writes with set/tag stall lookup.
// Optional per-entry age/timeout tracking is enabled by defining LLC_PENDING_TIMEOUT_EN.
module llc_pending_tracker #(
   parameter int unsigned N_ENTRIES = 4,
   parameter int unsigned SET_W     = 9,
   parameter int unsigned TAG_W     = 16,
   parameter int unsigned AGE_W     = 8,
   localparam int unsigned IDX_W    = $clog2(N_ENTRIES)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rst_state,
   input  logic                 alloc_valid,
   output logic                 alloc_ready,
   input  logic [SET_W-1:0]     alloc_set,
   input  logic [TAG_W-1:0]     alloc_tag,
   input  logic [1:0]           alloc_kind,
   output logic [IDX_W-1:0]     alloc_idx,
   input  logic                 clr_valid,
   input  logic [IDX_W-1:0]     clr_idx,
   input  logic [SET_W-1:0]     lookup_set,
   input  logic [TAG_W-1:0]     lookup_tag,
   output logic                 set_conflict,
   output logic                 line_hit,
   output logic [IDX_W-1:0]     hit_idx,
   output logic [N_ENTRIES-1:0] valid_vec,
   output logic                 recall_pending,
   output logic                 dma_read_pending,
   output logic                 dma_write_pending,
   output logic [IDX_W:0]       count,
   output logic                 clr_err,
   output logic [N_ENTRIES-1:0] timeout_vec
);

   typedef enum logic [1:0] {
      KIND_RECALL  = 2'd0,
      KIND_DMA_RD  = 2'd1,
      KIND_DMA_WR  = 2'd2,
      KIND_RSVD    = 2'd3
   } kind_e;

   logic [N_ENTRIES-1:0] valid_q;
   logic [SET_W-1:0]     set_q  [N_ENTRIES];
   logic [TAG_W-1:0]     tag_q  [N_ENTRIES];
   kind_e                kind_q [N_ENTRIES];

   logic free_found;
   logic alloc_fire;
   logic clr_hit;

   // Free-slot search looks only at registered valid bits, so alloc_ready has no path from alloc/clr inputs.
   always_comb begin
      free_found = 1'b0;
      alloc_idx  = '0;
      for (int unsigned i = 0; i < N_ENTRIES; i++) begin
         if (!valid_q[i] && !free_found) begin
            free_found = 1'b1;
            alloc_idx  = IDX_W'(i);
         end
      end
   end

   assign alloc_ready = free_found & ~rst_state;
   assign alloc_fire  = alloc_valid & alloc_ready & (kind_e'(alloc_kind) != KIND_RSVD);
   assign clr_hit     = clr_valid & valid_q[clr_idx];
   assign valid_vec   = valid_q;

   always_comb begin
      set_conflict      = 1'b0;
      line_hit          = 1'b0;
      hit_idx           = '0;
      recall_pending    = 1'b0;
      dma_read_pending  = 1'b0;
      dma_write_pending = 1'b0;
      count             = '0;
      for (int unsigned i = 0; i < N_ENTRIES; i++) begin
         if (valid_q[i]) begin
            count = count + 1'b1;
            if (set_q[i] == lookup_set) begin
               set_conflict = 1'b1;
               if (tag_q[i] == lookup_tag && !line_hit) begin
                  line_hit = 1'b1;
                  hit_idx  = IDX_W'(i);
               end
            end
            if (kind_q[i] == KIND_RECALL) recall_pending    = 1'b1;
            if (kind_q[i] == KIND_DMA_RD) dma_read_pending  = 1'b1;
            if (kind_q[i] == KIND_DMA_WR) dma_write_pending = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q <= '0;
         clr_err <= 1'b0;
         for (int unsigned i = 0; i < N_ENTRIES; i++) begin
            set_q[i]  <= '0;
            tag_q[i]  <= '0;
            kind_q[i] <= KIND_RECALL;
         end
      end else if (rst_state) begin
         valid_q <= '0;
         clr_err <= 1'b0;
      end else begin
         if (clr_valid && !valid_q[clr_idx]) clr_err <= 1'b1;
         if (clr_hit) valid_q[clr_idx] <= 1'b0;
         // The allocated slot is free pre-edge and the released slot is valid, so they never collide.
         if (alloc_fire) begin
            valid_q[alloc_idx] <= 1'b1;
            set_q[alloc_idx]   <= alloc_set;
            tag_q[alloc_idx]   <= alloc_tag;
            kind_q[alloc_idx]  <= kind_e'(alloc_kind);
         end
      end
   end

`ifdef LLC_PENDING_TIMEOUT_EN
   logic [AGE_W-1:0] age_q [N_ENTRIES];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < N_ENTRIES; i++) age_q[i] <= '0;
      end else if (rst_state) begin
         for (int unsigned i = 0; i < N_ENTRIES; i++) age_q[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < N_ENTRIES; i++) begin
            if ((clr_hit && clr_idx == IDX_W'(i)) || (alloc_fire && alloc_idx == IDX_W'(i)))
               age_q[i] <= '0;
            else if (valid_q[i] && age_q[i] != '1)
               age_q[i] <= age_q[i] + 1'b1;
         end
      end
   end

   always_comb begin
      timeout_vec = '0;
      for (int unsigned i = 0; i < N_ENTRIES; i++)
         timeout_vec[i] = valid_q[i] & (age_q[i] == '1);
   end
`else
   logic [31:0] unused_age_w;
   assign unused_age_w = AGE_W;
   assign timeout_vec  = '0;
`endif

endmodule

// File: tb/tb_llc_pending_tracker.sv
// Directed bench for llc_pending_tracker: table-level model checked every cycle plus literal test-plan checks.
module tb_llc_pending_tracker;
   localparam int N = 4;
   localparam int SW = 9;
   localparam int TW = 16;
   localparam int AW = 3;
   localparam int IW = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          rst_state = 1'b0;
   logic          alloc_valid = 1'b0;
   logic          alloc_ready;
   logic [SW-1:0] alloc_set = '0;
   logic [TW-1:0] alloc_tag = '0;
   logic [1:0]    alloc_kind = '0;
   logic [IW-1:0] alloc_idx;
   logic          clr_valid = 1'b0;
   logic [IW-1:0] clr_idx = '0;
   logic [SW-1:0] lookup_set = '0;
   logic [TW-1:0] lookup_tag = '0;
   logic          set_conflict, line_hit;
   logic [IW-1:0] hit_idx;
   logic [N-1:0]  valid_vec, timeout_vec;
   logic          recall_pending, dma_read_pending, dma_write_pending;
   logic [IW:0]   count;
   logic          clr_err;

   int errors = 0;
   int checks = 0;

   llc_pending_tracker #(.N_ENTRIES(N), .SET_W(SW), .TAG_W(TW), .AGE_W(AW)) dut (
      .clk(clk), .rst(rst), .rst_state(rst_state),
      .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_set(alloc_set),
      .alloc_tag(alloc_tag), .alloc_kind(alloc_kind), .alloc_idx(alloc_idx),
      .clr_valid(clr_valid), .clr_idx(clr_idx),
      .lookup_set(lookup_set), .lookup_tag(lookup_tag),
      .set_conflict(set_conflict), .line_hit(line_hit), .hit_idx(hit_idx),
      .valid_vec(valid_vec), .recall_pending(recall_pending),
      .dma_read_pending(dma_read_pending), .dma_write_pending(dma_write_pending),
      .count(count), .clr_err(clr_err), .timeout_vec(timeout_vec)
   );

   always #5 clk = ~clk;

   // Model: the table as a list of occupied slots with their contents.
   bit          m_valid [N];
   logic [1:0]  m_kind  [N];
   logic [SW-1:0] m_set [N];
   logic [TW-1:0] m_tag [N];
   int          m_age   [N];
   bit          m_err;
   bit          checking = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_valid[i] = 0; m_kind[i] = 0; m_set[i] = 0; m_tag[i] = 0; m_age[i] = 0;
      end
      m_err = 0;
   endtask

   function automatic int first_free();
      for (int i = 0; i < N; i++) if (!m_valid[i]) return i;
      return -1;
   endfunction

   task automatic model_edge();
      int slot;
      bit fire;
      slot = first_free();
      fire = alloc_valid && !rst_state && slot >= 0 && alloc_kind != 2'd3;
      if (rst_state) begin
         for (int i = 0; i < N; i++) begin m_valid[i] = 0; m_age[i] = 0; end
         m_err = 0;
      end else begin
         for (int i = 0; i < N; i++) if (m_valid[i] && m_age[i] < (1 << AW) - 1) m_age[i]++;
         if (clr_valid) begin
            if (m_valid[clr_idx]) begin m_valid[clr_idx] = 0; m_age[clr_idx] = 0; end
            else m_err = 1;
         end
         if (fire) begin
            m_valid[slot] = 1; m_kind[slot] = alloc_kind;
            m_set[slot] = alloc_set; m_tag[slot] = alloc_tag; m_age[slot] = 0;
         end
      end
   endtask

   always @(negedge clk) begin
      if (checking) begin
         int cnt, hit, slot;
         bit conf, rp, rdp, wp;
         logic [N-1:0] vv, tv;
         cnt = 0; hit = -1; conf = 0; rp = 0; rdp = 0; wp = 0; vv = '0; tv = '0;
         for (int i = 0; i < N; i++) begin
            if (m_valid[i]) begin
               cnt++;
               vv[i] = 1'b1;
               if (m_set[i] == lookup_set) conf = 1;
               if (m_set[i] == lookup_set && m_tag[i] == lookup_tag && hit < 0) hit = i;
               rp  |= (m_kind[i] == 2'd0);
               rdp |= (m_kind[i] == 2'd1);
               wp  |= (m_kind[i] == 2'd2);
`ifdef LLC_PENDING_TIMEOUT_EN
               tv[i] = (m_age[i] == (1 << AW) - 1);
`endif
            end
         end
         slot = first_free();
         chk("valid_vec", 32'(valid_vec), 32'(vv));
         chk("count", 32'(count), 32'(cnt));
         chk("alloc_ready", 32'(alloc_ready), 32'(slot >= 0 && !rst_state));
         chk("alloc_idx", 32'(alloc_idx), 32'(slot < 0 ? 0 : slot));
         chk("set_conflict", 32'(set_conflict), 32'(conf));
         chk("line_hit", 32'(line_hit), 32'(hit >= 0));
         chk("hit_idx", 32'(hit_idx), 32'(hit < 0 ? 0 : hit));
         chk("recall_pending", 32'(recall_pending), 32'(rp));
         chk("dma_read_pending", 32'(dma_read_pending), 32'(rdp));
         chk("dma_write_pending", 32'(dma_write_pending), 32'(wp));
         chk("clr_err", 32'(clr_err), 32'(m_err));
         chk("timeout_vec", 32'(timeout_vec), 32'(tv));
      end
   end

   // Inputs are set ~2 time units after a rising edge; this advances one clock and updates the model.
   task automatic cycle();
      @(posedge clk);
      model_edge();
      #2;
   endtask

   task automatic idle();
      alloc_valid = 0; clr_valid = 0; rst_state = 0;
   endtask

   task automatic set_alloc(input logic [SW-1:0] s, input logic [TW-1:0] t, input logic [1:0] k);
      alloc_valid = 1; alloc_set = s; alloc_tag = t; alloc_kind = k;
   endtask

   initial begin
      logic [TW-1:0] tags [4];
      tags[0] = 16'hAB00; tags[1] = 16'hAB01; tags[2] = 16'hABCD; tags[3] = 16'hAB03;
      model_reset();
      repeat (2) @(posedge clk);
      #2;
      chk("reset valid_vec", 32'(valid_vec), 0);
      chk("reset alloc_ready", 32'(alloc_ready), 1);
      chk("reset count", 32'(count), 0);
      chk("reset set_conflict", 32'(set_conflict), 0);
      rst = 1;
      checking = 1;
      cycle();

      for (int i = 0; i < 4; i++) begin
         set_alloc(9'h12, tags[i], 2'd1);
         #1 chk("fill alloc_idx", 32'(alloc_idx), 32'(i));
         cycle();
      end
      idle();
      #1;
      chk("full count", 32'(count), 4);
      chk("full alloc_ready", 32'(alloc_ready), 0);
      chk("full dma_read_pending", 32'(dma_read_pending), 1);

      lookup_set = 9'h12; lookup_tag = 16'hABCD;
      #1;
      chk("lookup set_conflict", 32'(set_conflict), 1);
      chk("lookup line_hit", 32'(line_hit), 1);
      chk("lookup hit_idx", 32'(hit_idx), 2);
      lookup_tag = 16'h0001;
      #1;
      chk("lookup miss set_conflict", 32'(set_conflict), 1);
      chk("lookup miss line_hit", 32'(line_hit), 0);
      cycle();

      clr_valid = 1; clr_idx = 1; set_alloc(9'h55, 16'h5555, 2'd0);
      #1 chk("full+clr alloc_ready", 32'(alloc_ready), 0);
      cycle();
      idle();
      #1;
      chk("after clr count", 32'(count), 3);
      chk("after clr alloc_ready", 32'(alloc_ready), 1);
      chk("after clr alloc_idx", 32'(alloc_idx), 1);

      set_alloc(9'h40, 16'h1234, 2'd2); lookup_set = 9'h40; lookup_tag = 16'h1234;
      #1 chk("same-cycle line_hit", 32'(line_hit), 0);
      cycle();
      idle();
      #1;
      chk("next-cycle line_hit", 32'(line_hit), 1);
      chk("next-cycle hit_idx", 32'(hit_idx), 1);

      clr_valid = 1; clr_idx = 3;
      cycle();
      cycle();
      idle();
      #1;
      chk("bad clr clr_err", 32'(clr_err), 1);
      chk("bad clr count", 32'(count), 3);
      repeat (2) cycle();
      chk("sticky clr_err", 32'(clr_err), 1);

      clr_valid = 1; clr_idx = 0; set_alloc(9'h12, 16'hABCD, 2'd0);
      lookup_set = 9'h12; lookup_tag = 16'hABCD;
      cycle();
      idle();
      #1;
      chk("alloc+clr count", 32'(count), 3);
      chk("dup hit_idx", 32'(hit_idx), 2);
      chk("recall_pending", 32'(recall_pending), 1);

      set_alloc(9'h77, 16'h7777, 2'd3);
      cycle();
      idle();
      #1 chk("rsvd kind valid_vec", 32'(valid_vec), 32'h0000000E);

      rst_state = 1; set_alloc(9'h01, 16'h0001, 2'd1);
      #1 chk("rst_state alloc_ready", 32'(alloc_ready), 0);
      cycle();
      idle();
      #1;
      chk("rst_state count", 32'(count), 0);
      chk("rst_state clr_err", 32'(clr_err), 0);

      for (int i = 0; i < 48; i++) begin
         alloc_valid = (i % 3) != 2;
         alloc_kind  = 2'(i % 4);
         alloc_set   = SW'((i * 5) % 8);
         alloc_tag   = TW'(i % 4);
         clr_valid   = (i % 2) == 1;
         clr_idx     = IW'((i * 3) % 4);
         lookup_set  = SW'((i * 7) % 8);
         lookup_tag  = TW'((i + 1) % 4);
         rst_state   = (i == 30);
         cycle();
      end
      idle();
      rst_state = 1;
      cycle();
      idle();

`ifdef LLC_PENDING_TIMEOUT_EN
      set_alloc(9'h21, 16'h0021, 2'd0);
      cycle();
      idle();
      for (int k = 0; k < 9; k++) begin
         #1 chk("timeout_vec[0]", 32'(timeout_vec[0]), 32'(k >= 7));
         cycle();
      end
      clr_valid = 1; clr_idx = 0;
      cycle();
      idle();
      #1 chk("timeout after release", 32'(timeout_vec[0]), 0);
`endif

      set_alloc(9'h30, 16'h0030, 2'd1);
      repeat (2) cycle();
      idle();
      rst = 0;
      model_reset();
      #1;
      chk("async rst valid_vec", 32'(valid_vec), 0);
      chk("async rst count", 32'(count), 0);
      cycle();
      rst = 1;
      cycle();

      checking = 0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
